clk_enable_gen: RTL
===================

Name: clk_enable_gen

Overview:
- Parametrised, fully synchronous successor to the fixed two-output PLL wrapper.
- Generates NUM_CLOCKS derived clock-enable ticks and registered divided square waves from a single reference clock.
- Divide ratio and phase are runtime-programmable per channel. A locked flag drops and re-settles on every reconfiguration.
- Sits between the board reference clock and the CPU/peripheral domains, which gate on en_out rather than on new clock nets.

Parameters:
- NUM_CLOCKS, 2, number of output channels (1..16)
- DIV_W, 8, width of each divide-ratio and phase field
- LOCK_CYCLES, 16, refclk cycles spent in SETTLE before locked asserts (>=1)
- DEFAULT_DIV, {8'd2,8'd1}, packed NUM_CLOCKS*DIV_W reset divisors; channel i is at bits [i*DIV_W +: DIV_W]

Ports:
- refclk  in  1  sole clock; all flops rising-edge
- rst  in  1  asynchronous, active-low reset; assert async, deassert sync to refclk externally
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  high only in LOCKED
- cfg_chan  in  $clog2(NUM_CLOCKS) (min 1)  target channel
- cfg_div  in  DIV_W  new divide ratio
- cfg_phase  in  DIV_W  new initial counter offset
- cfg_err  out  1  one-cycle pulse when an accepted request has cfg_chan >= NUM_CLOCKS
- en_out  out  NUM_CLOCKS  per-channel single-cycle tick
- clk_out  out  NUM_CLOCKS  per-channel registered divided waveform
- locked  out  1  all channels running with current configuration

Behaviour:
- Reset (rst=0) forces the following. State is SETTLE, settle counter is 0, div[i]=DEFAULT_DIV[i], phase[i]=0, cnt[i]=0. locked=0, cfg_ready=0, cfg_err=0, en_out=0, clk_out=0.
- Reset also discards any runtime configuration, including when asserted mid-operation.
- Effective period P[i] = (div[i]==0) ? 1 : div[i]. A value of 0 is treated as 1.
- FSM has two states, SETTLE and LOCKED.
  - SETTLE: settle counter increments each cycle. When it reaches LOCK_CYCLES-1, the next state is LOCKED. On that same edge, locked<=1 and cnt[i]<=(phase[i]<P[i] ? phase[i] : 0).
  - LOCKED: cnt[i] increments each cycle and wraps from P[i]-1 to 0.
  - LOCKED to SETTLE: on an accepted request (cfg_valid&&cfg_ready) with a valid channel. On that edge: div/phase of cfg_chan are updated, locked<=0, settle counter<=0, all cnt<=0.
- Timing: first cycle after reset release is settle cycle 0. locked reads 1 from cycle LOCK_CYCLES onward.
- en_out[i] = locked && cnt[i]==P[i]-1. This is decoded from registers only.
- clk_out[i] is registered. Its next value is 1 when the next cnt[i] < (P[i]+1)/2, else 0. It is forced to 0 while !locked.
  - Duty is 50% for even P; high phase is one cycle longer for odd P.
  - P=1 gives clk_out constant 1 and en_out every cycle.
- All channels restart together on relock, so their ticks are mutually phase-aligned.
- Accepted request with cfg_chan >= NUM_CLOCKS: cfg_err pulses the next cycle, no state change, locked stays 1.
- cfg_valid while cfg_ready=0: request is held off. The requester must keep cfg_valid and its fields stable until accepted.
- Back-to-back requests: the second cannot be accepted until locked returns (>= LOCK_CYCLES cycles later).
- No combinational path from any input to any output except cfg_ready (state decode only).

Decomposition:
- Package clk_enable_gen_pkg holds the state enum (SETTLE, LOCKED) and the function eff_period(div) implementing the 0→1 mapping.
- Natural sub-module: clk_div_channel, one per channel via generate. Inputs: refclk, rst, load, phase, period, run. Outputs: en, clk. It holds cnt and the clk_out flop.
- The top holds the FSM, the settle counter, the config registers and the handshake.

Test Plan:
- Reset release, defaults (div 1, 2), LOCK_CYCLES=16:
  - locked=0 for cycles 0-15 and 1 from cycle 16.
  - en_out[0] is 1 every cycle from 16. en_out[1] is 1 at cycles 17, 19, 21 and so on.
  - clk_out[1] toggles every cycle; clk_out[0] stays 1.
- Program ch1 div=5 phase=0 while locked:
  - cfg_ready drops and locked=0 for 16 cycles.
  - After relock, en_out[1] pulses every 5th cycle, first at relock+4.
  - clk_out[1] shows a 3-high/2-low pattern.
- Program ch0 div=4 phase=2:
  - First en_out[0] appears at relock+1, then every 4 cycles.
  - phase=7 with div=4 behaves as phase 0.
- Program div=0:
  - Behaves exactly as div=1.
  - With NUM_CLOCKS=3, cfg_chan=3 gives cfg_err for 1 cycle, locked stays 1, and outputs are unchanged.
- Hold cfg_valid during SETTLE: no acceptance until cfg_ready=1, then accepted on the first LOCKED cycle and relock restarts.
- Assert rst mid-LOCKED after reprogramming:
  - All outputs go 0 asynchronously.
  - After release, DEFAULT_DIV timing from scenario 1 is reproduced exactly.

Source files
------------

// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Holds the lock FSM state encoding and the divide-ratio to period mapping.
package clk_enable_gen_pkg;

  typedef enum logic {
    StSettle = 1'b0,
    StLocked = 1'b1
  } state_e;

  // A programmed ratio of 0 runs the channel at full rate, same as 1.
  function automatic int unsigned eff_period(input int unsigned div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Configuration handshake and per-channel outputs of clk_enable_gen.
// The master drives reconfiguration requests; the slave is the generator.
interface clk_enable_gen_if #(
  parameter int unsigned NUM_CLOCKS = 2,
  parameter int unsigned DIV_W      = 8
);

  localparam int unsigned ChanW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ChanW-1:0]      cfg_chan;
  logic [DIV_W-1:0]      cfg_div;
  logic [DIV_W-1:0]      cfg_phase;
  logic                  cfg_err;
  logic [NUM_CLOCKS-1:0] en_out;
  logic [NUM_CLOCKS-1:0] clk_out;
  logic                  locked;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_div,
    output cfg_phase,
    input  cfg_ready,
    input  cfg_err,
    input  en_out,
    input  clk_out,
    input  locked
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_div,
    input  cfg_phase,
    output cfg_ready,
    output cfg_err,
    output en_out,
    output clk_out,
    output locked
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: a wrapping phase counter plus a registered square wave.
// Produces a single-cycle tick on the last count of each period while running.
module clk_div_channel #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] phase,
  input  logic [DIV_W-1:0] period,
  input  logic             run,
  output logic             en,
  output logic             clk
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_live;
  logic             w_live_nxt;
  logic             r_clk;
  logic             w_clk_nxt;
  logic [DIV_W:0]   w_half;

  // High while the count is below ceil(P/2), so odd periods get the longer high phase.
  assign w_half = ({1'b0, period} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

  always_comb begin
    w_cnt_nxt  = '0;
    w_live_nxt = 1'b0;
    if (load) begin
      w_cnt_nxt  = (phase < period) ? phase : '0;
      w_live_nxt = 1'b1;
    end else if (run) begin
      w_cnt_nxt  = (r_cnt >= period - DIV_W'(1)) ? '0 : r_cnt + DIV_W'(1);
      w_live_nxt = 1'b1;
    end
    w_clk_nxt = w_live_nxt && ({1'b0, w_cnt_nxt} < w_half);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_live <= 1'b0;
      r_clk  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_live <= w_live_nxt;
      r_clk  <= w_clk_nxt;
    end
  end

  assign en  = r_live && (r_cnt == period - DIV_W'(1));
  assign clk = r_clk;

endmodule

// File: rtl/clk_enable_gen.sv
// Runtime-programmable clock-enable generator with a settle/lock handshake.
// Every accepted reconfiguration restarts all channels together after a fixed settle window.
module clk_enable_gen
  import clk_enable_gen_pkg::*;
#(
  parameter int unsigned                  NUM_CLOCKS  = 2,
  parameter int unsigned                  DIV_W       = 8,
  parameter int unsigned                  LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DEFAULT_DIV = {8'd2, 8'd1}
) (
  input  logic               refclk,
  input  logic               rst,
  clk_enable_gen_if.slave    bus
);

  localparam int unsigned      SettleW    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(LOCK_CYCLES - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [SettleW-1:0]    r_settle;
  logic [DIV_W-1:0]      r_div    [NUM_CLOCKS];
  logic [DIV_W-1:0]      r_phase  [NUM_CLOCKS];
  logic [DIV_W-1:0]      w_period [NUM_CLOCKS];
  logic                  r_cfg_err;
  logic                  w_accept;
  logic                  w_chan_ok;
  logic                  w_reconf;
  logic                  w_settle_done;
  logic                  w_locked;
  logic                  w_load;
  logic                  w_run;
  logic [NUM_CLOCKS-1:0] w_en;
  logic [NUM_CLOCKS-1:0] w_clk;

  assign w_accept      = bus.cfg_valid && (r_state == StLocked);
  assign w_chan_ok     = 32'(bus.cfg_chan) < NUM_CLOCKS;
  assign w_reconf      = w_accept && w_chan_ok;
  assign w_settle_done = (r_state == StSettle) && (r_settle == SettleLast);

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state <= StSettle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StSettle: if (w_settle_done) w_state_nxt = StLocked;
      StLocked: if (w_reconf)      w_state_nxt = StSettle;
      default:                     w_state_nxt = StSettle;
    endcase
  end

  // A bad-channel request is acknowledged but must not disturb the running channels.
  always_comb begin
    w_locked = (r_state == StLocked);
    w_load   = w_settle_done;
    w_run    = w_locked && !w_reconf;
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_settle <= '0;
    end else if ((r_state == StSettle) && !w_settle_done) begin
      r_settle <= r_settle + SettleW'(1);
    end else begin
      r_settle <= '0;
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        r_div[i]   <= DEFAULT_DIV[i*DIV_W +: DIV_W];
        r_phase[i] <= '0;
      end
    end else if (w_reconf) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        if (32'(bus.cfg_chan) == i) begin
          r_div[i]   <= bus.cfg_div;
          r_phase[i] <= bus.cfg_phase;
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && !w_chan_ok;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      w_period[i] = DIV_W'(eff_period(32'(r_div[i])));
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    clk_div_channel #(
      .DIV_W(DIV_W)
    ) u_chan (
      .refclk(refclk),
      .rst   (rst),
      .load  (w_load),
      .phase (r_phase[g]),
      .period(w_period[g]),
      .run   (w_run),
      .en    (w_en[g]),
      .clk   (w_clk[g])
    );
  end

  assign bus.cfg_ready = w_locked;
  assign bus.locked    = w_locked;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.en_out    = w_en;
  assign bus.clk_out   = w_clk;

endmodule
